as_gpio_arbiter: RTL and testbench
==================================

// Module: as_gpio_arbiter
// PURPOSE
//  Owns the GPIO output port (gpio_o/gpioAddr_o/cs_o) of as_top_mem and shares it between
//  the core store path and the JTAG debug path. CPU writes are buffered in a small FIFO.
//  Debug writes come from a single held request. Each granted write is one cs_o pulse,
//  followed by a programmable idle gap, so benches sampling on negedge see one event per write.
// PARAMETERS
//  NR_GPIOS     nr_gpios (as_pack)         data width of gpio_o
//  GPIO_AW      gpio_addr_width (as_pack)  width of gpioAddr_o
//  FIFO_DEPTH   4                          CPU write buffer entries; power of 2, >=2
//  HOLD_CYCLES  2                          idle cycles after each cs_o pulse; >=0
// PORTS
//  clk_i       in   1         system clock; all logic on rising edge
//  rst_i       in   1         synchronous, active-high reset
//  cpu_we_i    in   1         CPU GPIO store valid
//  cpu_addr_i  in   GPIO_AW   CPU GPIO address
//  cpu_data_i  in   NR_GPIOS  CPU GPIO data
//  cpu_rdy_o   out  1         FIFO not full; a write is accepted when cpu_we_i & cpu_rdy_o
//  dbg_we_i    in   1         debug write request (clk_i domain); held high until dbg_ack_o
//  dbg_addr_i  in   GPIO_AW   debug address; stable while dbg_we_i=1
//  dbg_data_i  in   NR_GPIOS  debug data; stable while dbg_we_i=1
//  dbg_ack_o   out  1         1-cycle pulse in the cycle cs_o is driven for the debug write
//  gpio_o      out  NR_GPIOS  registered GPIO data
//  gpioAddr_o  out  GPIO_AW   registered GPIO address
//  cs_o        out  1         registered 1-cycle strobe per issued write
//  busy_o      out  1         FSM not IDLE, or FIFO not empty
// BEHAVIOUR
//  - Reset values: gpio_o=0, gpioAddr_o=0, cs_o=0, dbg_ack_o=0, busy_o=0, cpu_rdy_o=1.
//    Reset also flushes the FIFO (ptrs/count=0), sets FSM=IDLE, hold counter=0 and last_grant=DBG.
//  - FIFO: push on accept. Pop in the DRIVE cycle of a CPU grant. Ptrs wrap mod FIFO_DEPTH.
//    Count width is $clog2(FIFO_DEPTH)+1. Push and pop in the same cycle leave the count
//    unchanged. No bypass: a write accepted into an empty FIFO is first visible next cycle.
//    cpu_rdy_o = (count != FIFO_DEPTH), decoded from the registered count.
//  - FSM IDLE: if the FIFO is non-empty or dbg_we_i=1, arbitrate, load the output regs
//    and go to DRIVE. Otherwise stay in IDLE with cs_o=0.
//  - FSM DRIVE: cs_o=1 for exactly 1 cycle. gpio_o/gpioAddr_o hold the granted entry.
//    dbg_ack_o=1 if this is the debug grant. Next state is HOLD (counter=HOLD_CYCLES)
//    if HOLD_CYCLES>0, else IDLE.
//  - FSM HOLD: cs_o=0, gpio_o/gpioAddr_o keep their last value. Decrement the counter.
//    At 1 go to IDLE.
//  - Arbitration is round-robin on contention: grant the requester not granted last,
//    then update last_grant on every grant. A single requester always wins.
//  - Latency, FSM idle: CPU accept in cycle N -> cs_o in N+2. dbg_we_i rising in N -> cs_o in N+1.
//  - Throughput: 1 write per (2+HOLD_CYCLES) cycles; HOLD_CYCLES=0 gives 1 write per 2 cycles.
//  - Reset mid-operation: buffered and in-flight writes are discarded and never strobed.
//    A debug request still held after reset is issued normally.
//  - dbg_we_i dropped before ack: that write is not issued. No partial strobes.
// CONFIGURATION
//  AS_GPIO_DBG_PRIO_EN defined: debug has strict priority over the FIFO on contention.
//    last_grant is unused, and a continuous debug stream can starve the CPU.
//  Undefined (default): round-robin as above. CPU wins the first contention after reset.
// TESTING
//  T1 reset 10 cycles, no requests -> cs_o=0, gpio_o=0, gpioAddr_o=0, cpu_rdy_o=1, busy_o=0
//  T2 CPU (addr 4,data 1) in N, (addr 4,data 5) in N+1, HOLD=2 -> cs_o at N+2 gpio 1,
//     cs_o at N+6 gpio 5, addr 4 both
//  T3 6 CPU writes data 1..6 on consecutive cycles, DEPTH=4, HOLD=2 -> cpu_rdy_o=0 after
//     5th accept, 6th stalls until a pop; strobes emitted 1..6 in order, none lost or repeated
//  T4 FIFO non-empty and dbg_we_i=1 (addr 2,data 0xA) together after reset -> CPU strobe,
//     then debug strobe with dbg_ack_o 1 cycle coincident, then CPU; strict alternation
//  T5 rst_i for 1 cycle with 3 FIFO entries queued, FSM in HOLD -> no further cs_o;
//     busy_o=0 and cpu_rdy_o=1 in the cycle after reset
//  T6 AS_GPIO_DBG_PRIO_EN defined, T4 stimulus -> debug strobed first, and every held
//     debug request wins over the CPU

Source files
------------

// File: rtl/as_gpio_arbiter.sv
// as_gpio_arbiter: shares the GPIO output port between a FIFO-buffered CPU store path and a
// held debug write request. Define AS_GPIO_DBG_PRIO_EN for strict debug priority (default round-robin).
module as_gpio_arbiter #(
  parameter int unsigned NR_GPIOS    = 8,
  parameter int unsigned GPIO_AW     = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cpu_we_i,
  input  logic [GPIO_AW-1:0]  cpu_addr_i,
  input  logic [NR_GPIOS-1:0] cpu_data_i,
  output logic                cpu_rdy_o,
  input  logic                dbg_we_i,
  input  logic [GPIO_AW-1:0]  dbg_addr_i,
  input  logic [NR_GPIOS-1:0] dbg_data_i,
  output logic                dbg_ack_o,
  output logic [NR_GPIOS-1:0] gpio_o,
  output logic [GPIO_AW-1:0]  gpioAddr_o,
  output logic                cs_o,
  output logic                busy_o
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned HW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam int unsigned EW = GPIO_AW + NR_GPIOS;

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_HOLD} state_e;

  state_e              state_q, state_d;
  logic [EW-1:0]       mem_q [FIFO_DEPTH];
  logic [EW-1:0]       mem_d [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
  logic [NR_GPIOS-1:0] gpio_q, gpio_d;
  logic [GPIO_AW-1:0]  addr_q, addr_d;
  logic                cs_q, cs_d;
  logic                ack_q, ack_d;
  logic                fifo_ne, fifo_rdy, push, pop;
  logic                grant_dbg, grant_cpu;
`ifndef AS_GPIO_DBG_PRIO_EN
  logic                last_dbg_q, last_dbg_d;
`endif

  always_comb begin
    fifo_ne  = (count_q != '0);
    fifo_rdy = (count_q != CW'(FIFO_DEPTH));
    push     = cpu_we_i & fifo_rdy;
    // A DRIVE cycle without ack is always a CPU grant, so the head is retired then.
    pop      = (state_q == ST_DRIVE) & ~ack_q;

`ifdef AS_GPIO_DBG_PRIO_EN
    grant_dbg = dbg_we_i;
`else
    grant_dbg = dbg_we_i & (~fifo_ne | ~last_dbg_q);
`endif
    grant_cpu = fifo_ne & ~grant_dbg;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {cpu_addr_i, cpu_data_i};
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gpio_d     = gpio_q;
    addr_d     = addr_q;
    cs_d       = 1'b0;
    ack_d      = 1'b0;
`ifndef AS_GPIO_DBG_PRIO_EN
    last_dbg_d = last_dbg_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (grant_dbg | grant_cpu) begin
          state_d = ST_DRIVE;
          cs_d    = 1'b1;
          ack_d   = grant_dbg;
`ifndef AS_GPIO_DBG_PRIO_EN
          last_dbg_d = grant_dbg;
`endif
          if (grant_dbg) {addr_d, gpio_d} = {dbg_addr_i, dbg_data_i};
          else           {addr_d, gpio_d} = mem_q[rd_ptr_q];
        end
      end
      ST_DRIVE: begin
        if (HOLD_CYCLES > 0) begin
          state_d    = ST_HOLD;
          hold_cnt_d = HW'(HOLD_CYCLES);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        hold_cnt_d = hold_cnt_q - HW'(1);
        if (hold_cnt_q <= HW'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_cnt_q <= '0;
      gpio_q     <= '0;
      addr_q     <= '0;
      cs_q       <= 1'b0;
      ack_q      <= 1'b0;
`ifndef AS_GPIO_DBG_PRIO_EN
      last_dbg_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hold_cnt_q <= hold_cnt_d;
      gpio_q     <= gpio_d;
      addr_q     <= addr_d;
      cs_q       <= cs_d;
      ack_q      <= ack_d;
`ifndef AS_GPIO_DBG_PRIO_EN
      last_dbg_q <= last_dbg_d;
`endif
    end
    // Storage needs no reset: entries are only read while count_q is non-zero.
    mem_q <= mem_d;
  end

  assign cpu_rdy_o  = fifo_rdy;
  assign dbg_ack_o  = ack_q;
  assign gpio_o     = gpio_q;
  assign gpioAddr_o = addr_q;
  assign cs_o       = cs_q;
  assign busy_o     = (state_q != ST_IDLE) | fifo_ne;

endmodule

// File: tb/tb_as_gpio_arbiter.sv
// tb_as_gpio_arbiter: directed and randomized checks of as_gpio_arbiter against a
// transaction-timing reference model; follows AS_GPIO_DBG_PRIO_EN when defined.
`timescale 1ns/1ps
module tb_as_gpio_arbiter;
  localparam int NW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 4;
  localparam int HOLD  = 2;
  localparam int VW    = 4 + AW + NW;
  localparam logic [VW-1:0] RST_V = {4'b0010, {(AW+NW){1'b0}}};
`ifdef AS_GPIO_DBG_PRIO_EN
  localparam logic [5:0] SEQ_EXP = 6'b111000;
`else
  localparam logic [5:0] SEQ_EXP = 6'b010101;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_we, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr, gpio_addr;
  logic [NW-1:0] cpu_data, dbg_data, gpio;
  logic          cpu_rdy, dbg_ack, cs, busy;

  always #5 clk = ~clk;

  as_gpio_arbiter #(
    .NR_GPIOS    (NW),
    .GPIO_AW     (AW),
    .FIFO_DEPTH  (DEPTH),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cpu_we_i   (cpu_we),
    .cpu_addr_i (cpu_addr),
    .cpu_data_i (cpu_data),
    .cpu_rdy_o  (cpu_rdy),
    .dbg_we_i   (dbg_we),
    .dbg_addr_i (dbg_addr),
    .dbg_data_i (dbg_data),
    .dbg_ack_o  (dbg_ack),
    .gpio_o     (gpio),
    .gpioAddr_o (gpio_addr),
    .cs_o       (cs),
    .busy_o     (busy)
  );

  // Reference model: writes are tracked as timestamped transactions. A grant at cycle t
  // strobes at t+1 and blocks arbitration until t+2+HOLD; CPU entries are visible the
  // cycle after their push and leave the buffer in their strobe cycle.
  typedef struct packed { logic [AW-1:0] a; logic [NW-1:0] d; } ent_t;
  ent_t fifo_m[$];
  int   push_t[$];
  int   t_m, next_arb, strobe_t;
  logic strobe_dbg, last_dbg;
  ent_t strobe_e, out_e;
  logic exp_cs, exp_ack, exp_rdy, exp_busy;
  int   checks = 0;
  int   errors = 0;

  task automatic mdl_clear(input int first_idle);
    fifo_m.delete();
    push_t.delete();
    next_arb   = first_idle;
    strobe_t   = -1;
    strobe_dbg = 1'b0;
    last_dbg   = 1'b1;
    strobe_e   = '0;
    out_e      = '0;
  endtask

  task automatic mdl_step(output logic [VW-1:0] exp_v);
    logic cpu_req, gnt_dbg;
    ent_t e;
    exp_cs = (t_m == strobe_t);
    if (exp_cs) out_e = strobe_e;
    exp_ack  = exp_cs & strobe_dbg;
    exp_rdy  = (fifo_m.size() != DEPTH);
    exp_busy = (t_m < next_arb) || (fifo_m.size() != 0);
    exp_v    = {exp_cs, exp_ack, exp_rdy, exp_busy, out_e};
    if (rst) begin
      mdl_clear(t_m + 1);
    end else begin
      if (exp_cs && !strobe_dbg) begin
        void'(fifo_m.pop_front());
        void'(push_t.pop_front());
      end
      if (t_m >= next_arb) begin
        cpu_req = (fifo_m.size() != 0) && (push_t[0] < t_m);
`ifdef AS_GPIO_DBG_PRIO_EN
        gnt_dbg = dbg_we;
`else
        gnt_dbg = dbg_we && (!cpu_req || !last_dbg);
`endif
        if (cpu_req || dbg_we) begin
          strobe_t   = t_m + 1;
          next_arb   = t_m + 2 + HOLD;
          strobe_dbg = gnt_dbg;
          last_dbg   = gnt_dbg;
          if (gnt_dbg) begin
            strobe_e.a = dbg_addr;
            strobe_e.d = dbg_data;
          end else begin
            strobe_e = fifo_m[0];
          end
        end
      end
      if (cpu_we && exp_rdy) begin
        e.a = cpu_addr;
        e.d = cpu_data;
        fifo_m.push_back(e);
        push_t.push_back(t_m);
      end
    end
    t_m++;
  endtask

  // One clock: sample outputs on negedge, advance the model, return after the next posedge.
  task automatic tick(output logic [VW-1:0] got_v, output logic [VW-1:0] exp_v);
    @(negedge clk);
    got_v = {cs, dbg_ack, cpu_rdy, busy, gpio_addr, gpio};
    mdl_step(exp_v);
    @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    logic [VW-1:0] g, e;
    cpu_we = 1'b0;
    dbg_we = 1'b0;
    rst    = 1'b1;
    tick(g, e);
    rst    = 1'b0;
  endtask

  task automatic test_reset();
    logic [VW-1:0] g, e;
    cpu_we = 1'b0;
    dbg_we = 1'b0;
    rst    = 1'b1;
    for (int n = 0; n < 12; n++) begin
      if (n == 10) rst = 1'b0;
      tick(g, e);
      checks++;
      if (g !== RST_V) begin
        errors++;
        $display("FAIL reset cyc %0d: got %h want %h", n, g, RST_V);
      end
    end
  endtask

  task automatic test_cpu_pair();
    logic [VW-1:0]    g, e;
    logic [AW+NW-1:0] w0, w1;
    int               s_n[$];
    logic [VW-1:0]    s_v[$];
    w0 = {AW'(4), NW'(1)};
    w1 = {AW'(4), NW'(5)};
    start_test();
    for (int n = 0; n < 12; n++) begin
      cpu_we   = (n < 2);
      cpu_addr = AW'(4);
      cpu_data = (n == 0) ? NW'(1) : NW'(5);
      tick(g, e);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL cpu_pair cyc %0d: got %h want %h", n, g, e);
      end
      if (g[VW-1]) begin
        s_n.push_back(n);
        s_v.push_back(g);
      end
    end
    cpu_we = 1'b0;
    checks++;
    if (s_n.size() != 2) begin
      errors++;
      $display("FAIL cpu_pair_count: got %0d strobes want 2", s_n.size());
    end else begin
      checks++;
      if (s_n[0] != 2 || s_n[1] != 6) begin
        errors++;
        $display("FAIL cpu_pair_latency: got cycles %0d,%0d want 2,6", s_n[0], s_n[1]);
      end
      checks++;
      if (s_v[0][AW+NW-1:0] !== w0 || s_v[1][AW+NW-1:0] !== w1) begin
        errors++;
        $display("FAIL cpu_pair_data: got %h,%h want %h,%h",
                 s_v[0][AW+NW-1:0], s_v[1][AW+NW-1:0], w0, w1);
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [VW-1:0] g, e;
    logic          rdy_hist [48];
    logic [NW-1:0] strobes[$];
    int            k, acc5, acc6;
    k    = 1;
    acc5 = -1;
    acc6 = -1;
    start_test();
    for (int n = 0; n < 40; n++) begin
      cpu_we   = (k <= 6);
      cpu_addr = AW'(k);
      cpu_data = NW'(k);
      tick(g, e);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL fifo_full cyc %0d: got %h want %h", n, g, e);
      end
      rdy_hist[n] = g[VW-3];
      if (g[VW-1]) strobes.push_back(g[NW-1:0]);
      if (cpu_we && exp_rdy) begin
        if (k == 5) acc5 = n;
        if (k == 6) acc6 = n;
        k++;
      end
    end
    cpu_we = 1'b0;
    checks++;
    if (acc5 < 0 || acc5 > 38 || rdy_hist[acc5 + 1] !== 1'b0) begin
      errors++;
      $display("FAIL fifo_full_rdy: 5th accept at %0d, rdy after it not 0 (want 0)", acc5);
    end
    checks++;
    if (acc6 < acc5 + 2) begin
      errors++;
      $display("FAIL fifo_full_stall: got 6th accept at %0d want >= %0d", acc6, acc5 + 2);
    end
    checks++;
    if (strobes.size() != 6) begin
      errors++;
      $display("FAIL fifo_full_count: got %0d strobes want 6", strobes.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (strobes[i] !== NW'(i + 1)) begin
          errors++;
          $display("FAIL fifo_full_order[%0d]: got %0d want %0d", i, strobes[i], i + 1);
        end
      end
    end
  endtask

  task automatic test_contention();
    logic [VW-1:0] g, e;
    logic [5:0]    seq;
    int            ns, dbg_sent, raise_at;
    seq      = '0;
    ns       = 0;
    dbg_sent = 0;
    raise_at = 1;
    start_test();
    for (int n = 0; n < 30; n++) begin
      cpu_we   = (n < 3);
      cpu_addr = AW'(1);
      cpu_data = NW'(8'h11 + n);
      if (!dbg_we && dbg_sent < 3 && n >= raise_at) begin
        dbg_we   = 1'b1;
        dbg_addr = AW'(2);
        dbg_data = NW'(8'h0A + dbg_sent);
      end
      tick(g, e);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL contention cyc %0d: got %h want %h", n, g, e);
      end
      if (g[VW-1]) begin
        if (ns < 6) seq[5 - ns] = g[VW-2];
        ns++;
      end
      if (exp_ack) begin
        dbg_we   = 1'b0;
        dbg_sent++;
        raise_at = n + 2;
      end
    end
    cpu_we = 1'b0;
    dbg_we = 1'b0;
    checks++;
    if (ns != 6 || seq !== SEQ_EXP) begin
      errors++;
      $display("FAIL contention_order: got %0d strobes seq %b want 6 seq %b", ns, seq, SEQ_EXP);
    end
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] g, e;
    int            post_cs;
    post_cs = 0;
    start_test();
    for (int n = 0; n < 20; n++) begin
      cpu_we   = (n < 4);
      cpu_addr = AW'(n);
      cpu_data = NW'(8'h20 + n);
      rst      = (n == 4);
      tick(g, e);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL reset_mid cyc %0d: got %h want %h", n, g, e);
      end
      if (n == 5) begin
        checks++;
        if (g[VW-4] !== 1'b0 || g[VW-3] !== 1'b1) begin
          errors++;
          $display("FAIL reset_mid_flags: got busy %b rdy %b want busy 0 rdy 1", g[VW-4], g[VW-3]);
        end
      end
      if (n >= 5 && g[VW-1]) post_cs++;
    end
    rst    = 1'b0;
    cpu_we = 1'b0;
    checks++;
    if (post_cs != 0) begin
      errors++;
      $display("FAIL reset_mid_discard: got %0d strobes after reset want 0", post_cs);
    end
  endtask

  task automatic test_dbg_abort();
    logic [VW-1:0] g, e;
    int            acks;
    logic          done;
    logic [NW-1:0] ack_data;
    acks     = 0;
    done     = 1'b0;
    ack_data = '0;
    start_test();
    for (int n = 0; n < 20; n++) begin
      cpu_we   = (n == 0);
      cpu_addr = AW'(1);
      cpu_data = NW'(8'h31);
      dbg_we   = (n == 2 || n == 3) || (n >= 8 && !done);
      dbg_addr = (n < 8) ? AW'(3) : AW'(5);
      dbg_data = (n < 8) ? NW'(8'h55) : NW'(8'h66);
      tick(g, e);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL dbg_abort cyc %0d: got %h want %h", n, g, e);
      end
      if (g[VW-2]) begin
        acks++;
        ack_data = g[NW-1:0];
      end
      if (exp_ack) done = 1'b1;
    end
    dbg_we = 1'b0;
    cpu_we = 1'b0;
    checks++;
    if (acks != 1 || ack_data !== NW'(8'h66)) begin
      errors++;
      $display("FAIL dbg_abort_issue: got %0d acks data %h want 1 ack data 66", acks, ack_data);
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] g, e;
    start_test();
    for (int n = 0; n < 800; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      cpu_we   = ($urandom_range(0, 2) != 0);
      cpu_addr = AW'($urandom);
      cpu_data = NW'($urandom);
      if (!dbg_we) begin
        if ($urandom_range(0, 5) == 0) begin
          dbg_we   = 1'b1;
          dbg_addr = AW'($urandom);
          dbg_data = NW'($urandom);
        end
      end else if (!(strobe_t == t_m && strobe_dbg) && $urandom_range(0, 19) == 0) begin
        dbg_we = 1'b0;
      end
      tick(g, e);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL random cyc %0d: got %h want %h", n, g, e);
      end
      if (exp_ack) dbg_we = 1'b0;
    end
    rst    = 1'b0;
    cpu_we = 1'b0;
    dbg_we = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = '0;
    cpu_data = '0;
    dbg_we   = 1'b0;
    dbg_addr = '0;
    dbg_data = '0;
    @(posedge clk);
    #1;
    t_m = 0;
    mdl_clear(0);
    test_reset();
    test_cpu_pair();
    test_fifo_full();
    test_contention();
    test_reset_mid();
    test_dbg_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
